// File: rtl/lcg_check_pkg.sv
// Shared constants, FSM state type and sizing helper for the LCG stream checker.
package lcg_check_pkg;

  localparam logic [31:0] LCG_MUL_DEF = 32'h41C64E6D;
  localparam logic [31:0] LCG_INC_DEF = 32'h0000_3039;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GEN  = 2'd1,
    WAIT = 2'd2
  } chk_state_e;

  // Number of 32-bit LCG draws needed to cover one beat.
  function automatic int unsigned nchunk(input int unsigned data_w);
    return (data_w + 32'd31) / 32'd32;
  endfunction

endpackage

// File: rtl/lcg32_core.sv
// 32-bit linear congruential generator: loadable state register with step enable.
module lcg32_core #(
  parameter logic [31:0] MUL = 32'h41C64E6D,
  parameter logic [31:0] INC = 32'h0000_3039
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        step,
  output logic [31:0] state
);

  logic [31:0] state_nxt;

  assign state_nxt = state * MUL + INC;

  // Load has priority over step; a step advances the generator by one draw.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= '0;
    end else if (load) begin
      state <= seed;
    end else if (step) begin
      state <= state_nxt;
    end
  end

endmodule

// File: rtl/lcg_stream_checker.sv
// Receive-side LCG stream checker: regenerates the expected beat from a seed,
// compares each accepted beat and keeps beat/mismatch statistics.
// DATA_W must exceed 32 (at least two draws per beat).
module lcg_stream_checker
  import lcg_check_pkg::*;
#(
  parameter int unsigned DATA_W  = 139,
  parameter logic [31:0] LCG_MUL = LCG_MUL_DEF,
  parameter logic [31:0] LCG_INC = LCG_INC_DEF,
  parameter int unsigned ERR_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              seed_load,
  input  logic [31:0]       seed,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic [31:0]       beat_count,
  output logic [ERR_W-1:0]  err_count,
  output logic              err_flag,
  output logic [31:0]       first_err_beat,
  output logic              locked
);

  localparam int unsigned NCHUNK = nchunk(DATA_W);
  localparam int unsigned LO_W   = 32 * (NCHUNK - 1);
  localparam int unsigned LAST_W = DATA_W - LO_W;
  localparam int unsigned CNT_W  = $clog2(NCHUNK + 1);
  localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NCHUNK - 1);

  chk_state_e        st;
  logic [CNT_W-1:0]  chunk_idx;
  logic [31:0]       lcg_state;
  logic [LO_W-1:0]   exp_lo;
  logic [DATA_W-1:0] exp_word;
  logic              gen_step;
  logic              accept;
  logic              mismatch;

  assign in_ready = (st == WAIT);
  assign gen_step = (st == GEN) && !seed_load;
  assign accept   = in_ready && in_valid && !seed_load;

  // A draw lands in its chunk slot the cycle after its step; the final
  // chunk is read live from the generator, which holds it through WAIT.
  assign exp_word = {lcg_state[LAST_W-1:0], exp_lo};
  assign mismatch = (in_data != exp_word);

  lcg32_core #(
    .MUL(LCG_MUL),
    .INC(LCG_INC)
  ) u_lcg (
    .clk  (clk),
    .rst_n(rst_n),
    .load (seed_load),
    .seed (seed),
    .step (gen_step),
    .state(lcg_state)
  );

  // FSM and chunk counter; seed_load restarts generation from any state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= IDLE;
      chunk_idx <= '0;
      locked    <= 1'b0;
    end else if (seed_load) begin
      st        <= GEN;
      chunk_idx <= '0;
      locked    <= 1'b1;
    end else begin
      case (st)
        GEN: begin
          if (chunk_idx == LAST_CHUNK) begin
            st        <= WAIT;
            chunk_idx <= '0;
          end else begin
            chunk_idx <= chunk_idx + CNT_W'(1);
          end
        end
        WAIT: begin
          if (in_valid) st <= GEN;
        end
        default: st <= st;
      endcase
    end
  end

  // Expected-word assembly for all chunks below the final one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_lo <= '0;
    end else if (gen_step && (chunk_idx != '0)) begin
      exp_lo[{chunk_idx - CNT_W'(1), 5'd0} +: 32] <= lcg_state;
    end
  end

  // Beat and mismatch statistics, cleared by seed_load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_count     <= '0;
      err_count      <= '0;
      err_flag       <= 1'b0;
      first_err_beat <= '0;
    end else if (seed_load) begin
      beat_count     <= '0;
      err_count      <= '0;
      err_flag       <= 1'b0;
      first_err_beat <= '0;
    end else if (accept) begin
      beat_count <= beat_count + 32'd1;
      if (mismatch) begin
        if (err_count != '1) err_count <= err_count + ERR_W'(1);
        if (!err_flag) begin
          err_flag       <= 1'b1;
          first_err_beat <= beat_count;
        end
      end
    end
  end

endmodule

// File: tb/tb_lcg_stream_checker.sv
// Self-checking bench for lcg_stream_checker: table-driven stream runs plus
// hand-written sequences for reset, seed_load/accept collision, saturation
// and back-to-back throughput.
module tb_lcg_stream_checker;

  localparam int unsigned DW = 139;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          seed_load = 1'b0;
  logic [31:0]   seed = '0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [DW-1:0] in_data4;

  logic          rdy, locked, flag;
  logic [31:0]   beats, first;
  logic [15:0]   errs;
  logic          rdy4, locked4, flag4;
  logic [31:0]   beats4, first4;
  logic [3:0]    errs4;

  // Second instance always sees a corrupted copy of the data (bit 0 flipped).
  assign in_data4 = in_data ^ {{(DW-1){1'b0}}, 1'b1};

  lcg_stream_checker #(.DATA_W(DW), .ERR_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed(seed),
    .in_valid(in_valid), .in_ready(rdy), .in_data(in_data),
    .beat_count(beats), .err_count(errs), .err_flag(flag),
    .first_err_beat(first), .locked(locked)
  );

  lcg_stream_checker #(.DATA_W(DW), .ERR_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed(seed),
    .in_valid(in_valid), .in_ready(rdy4), .in_data(in_data4),
    .beat_count(beats4), .err_count(errs4), .err_flag(flag4),
    .first_err_beat(first4), .locked(locked4)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] m_state = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] lcg(input logic [31:0] s);
    return s * 32'h41C64E6D + 32'h0000_3039;
  endfunction

  task automatic next_beat(output logic [DW-1:0] b);
    logic [159:0] w;
    for (int k = 0; k < 5; k++) begin
      m_state = lcg(m_state);
      w[k*32 +: 32] = m_state;
    end
    b = w[DW-1:0];
  endtask

  // All tasks start and end just after a falling edge.
  task automatic load_seed(input logic [31:0] s);
    seed_load = 1'b1;
    seed      = s;
    @(negedge clk);
    seed_load = 1'b0;
    m_state   = s;
  endtask

  task automatic send_beat(input logic [DW-1:0] d);
    int w = 0;
    while (!rdy && w < 40) begin
      @(negedge clk);
      w++;
    end
    if (!rdy) begin
      chk("ready_timeout", 64'd0, 64'd1);
    end else begin
      in_valid = 1'b1;
      in_data  = d;
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = ~d;
    end
  endtask

  task automatic send_n(input int n, input int bad_beat, input int bad_bit);
    logic [DW-1:0] b;
    for (int i = 0; i < n; i++) begin
      next_beat(b);
      if (i == bad_beat) b[bad_bit] = ~b[bad_bit];
      send_beat(b);
    end
  endtask

  typedef struct {
    logic [31:0] seed;
    int          nbeats;
    int          bad_beat;
    int          bad_bit;
    logic [31:0] exp_beats;
    logic [15:0] exp_err;
    logic        exp_flag;
    logic [31:0] exp_first;
  } vec_t;

  vec_t vecs[4];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] b;
    logic [DW-1:0] cur;
    int lowcnt, hi, nacc, last, bad;

    vecs[0] = '{32'd0,          200, -1, 0,   32'd200, 16'd0, 1'b0, 32'd0};
    vecs[1] = '{32'd0,          8,   3,  5,   32'd8,   16'd1, 1'b1, 32'd3};
    vecs[2] = '{32'd12345,      4,   0,  138, 32'd4,   16'd1, 1'b1, 32'd0};
    vecs[3] = '{32'hDEADBEEF,   10,  -1, 0,   32'd10,  16'd0, 1'b0, 32'd0};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", rdy, 0);
    chk("rst_locked", locked, 0);
    chk("rst_beats", beats, 0);
    chk("rst_errs", errs, 0);
    chk("rst_flag", flag, 0);
    chk("rst_first", first, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", rdy, 0);

    // Known first draws of seed 0
    load_seed(32'd0);
    chk("locked_after_load", locked, 1);
    next_beat(b);
    b[31:0]  = 32'h0000_3039;
    b[63:32] = 32'hD3DC167E;
    send_beat(b);
    chk("const_beats", beats, 1);
    chk("const_errs", errs, 0);

    // Table-driven stream runs
    for (int v = 0; v < 4; v++) begin
      load_seed(vecs[v].seed);
      send_n(vecs[v].nbeats, vecs[v].bad_beat, vecs[v].bad_bit);
      chk($sformatf("v%0d_beats", v), beats, vecs[v].exp_beats);
      chk($sformatf("v%0d_errs", v), errs, vecs[v].exp_err);
      chk($sformatf("v%0d_flag", v), flag, vecs[v].exp_flag);
      chk($sformatf("v%0d_first", v), first, vecs[v].exp_first);
      chk($sformatf("v%0d_errs4", v), errs4, (vecs[v].nbeats > 15) ? 15 : vecs[v].nbeats);
      chk($sformatf("v%0d_first4", v), first4, 0);
      chk($sformatf("v%0d_flag4", v), flag4, 1);
    end

    // seed_load colliding with an accept: seed wins, beat not counted
    lowcnt = 0;
    while (!rdy && lowcnt < 40) begin
      @(negedge clk);
      lowcnt++;
    end
    chk("coll_ready_before", rdy, 1);
    in_valid  = 1'b1;
    in_data   = '1;
    seed_load = 1'b1;
    seed      = 32'd362960400;
    @(negedge clk);
    in_valid  = 1'b0;
    seed_load = 1'b0;
    m_state   = 32'd362960400;
    chk("coll_beats", beats, 0);
    chk("coll_errs", errs, 0);
    chk("coll_flag", flag, 0);
    lowcnt = 0;
    while (!rdy && lowcnt < 20) begin
      lowcnt++;
      @(negedge clk);
    end
    chk("coll_ready_low_cycles", lowcnt, 5);
    send_n(5, -1, 0);
    chk("coll_new_beats", beats, 5);
    chk("coll_new_errs", errs, 0);

    // Saturation of the 4-bit error counter
    load_seed(32'd7);
    send_n(14, -1, 0);
    chk("sat_errs4_14", errs4, 14);
    send_n(1, -1, 0);
    chk("sat_errs4_15", errs4, 15);
    send_n(3, -1, 0);
    chk("sat_errs4_hold", errs4, 15);
    chk("sat_beats4", beats4, 18);
    chk("sat_first4", first4, 0);
    chk("sat_main_errs", errs, 0);

    // Reset mid-GEN clears everything and parks in IDLE
    load_seed(32'd5);
    send_n(3, 1, 70);
    chk("pre_rst_first", first, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_beats", beats, 0);
    chk("mid_rst_errs", errs, 0);
    chk("mid_rst_flag", flag, 0);
    chk("mid_rst_first", first, 0);
    chk("mid_rst_locked", locked, 0);
    chk("mid_rst_ready", rdy, 0);
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b1;
    hi = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (rdy) hi++;
    end
    in_valid = 1'b0;
    chk("post_rst_ready_seen", hi, 0);
    chk("post_rst_beats", beats, 0);
    chk("post_rst_locked", locked, 0);
    load_seed(32'd5);
    send_n(2, -1, 0);
    chk("post_rst_restart_beats", beats, 2);
    chk("post_rst_restart_errs", errs, 0);

    // Back-to-back: in_valid held high, one accept every 6 cycles
    load_seed(32'd99);
    next_beat(cur);
    in_valid = 1'b1;
    nacc = 0;
    last = -1;
    bad  = 0;
    for (int c = 0; c < 60; c++) begin
      if (rdy) begin
        in_data = cur;
        if (last >= 0 && (c - last) != 6) bad++;
        last = c;
        nacc++;
        next_beat(cur);
      end else begin
        in_data = ~cur;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("tput_accepts", nacc, 10);
    chk("tput_spacing_errors", bad, 0);
    chk("tput_beats", beats, 10);
    chk("tput_errs", errs, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lcg_stream_checker.md
Name: lcg_stream_checker

Overview:
- Receive-side counterpart to the LCG stimulus driver used by the fuzz benches.
- Regenerates the same deterministic LCG word stream from a loaded seed and compares each accepted beat against it.
- Accepts beats over a valid/ready interface; counts beats and mismatches.
- Sits at the far end of a DUT data path or loopback so stream integrity can be checked in synthesizable logic, without a simulator-side compare.

Parameters:
- DATA_W, 139, beat width in bits; NCHUNK = ceil(DATA_W/32) LCG draws per beat.
- LCG_MUL, 32'h41C64E6D, LCG multiplier.
- LCG_INC, 32'h3039, LCG increment.
- ERR_W, 16, error counter width (saturating).

Ports:
- clk  input  1  clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- seed_load  input  1  one-cycle pulse: load seed, clear statistics, restart stream.
- seed  input  32  seed value, sampled when seed_load=1.
- in_valid  input  1  beat available.
- in_ready  output  1  checker can accept a beat.
- in_data  input  DATA_W  received beat.
- beat_count  output  32  beats accepted since last seed_load.
- err_count  output  ERR_W  mismatching beats, saturating.
- err_flag  output  1  sticky; set on first mismatch.
- first_err_beat  output  32  beat_count value of the first mismatching beat.
- locked  output  1  a seed has been loaded and the checker is active.

Behaviour:
- LCG step: next = (state*LCG_MUL + LCG_INC) mod 2^32. Exactly one step per GEN cycle, no multiplier sharing across cycles.
- Expected beat: draws d1..dNCHUNK taken after the seed, lowest chunk first.
  - Bits [32k+31:32k] = d(k+1).
  - Final chunk truncated to its low DATA_W-32*(NCHUNK-1) bits. For 139 bits this is d5[10:0] into [138:128].
- The LCG state persists across beats: beat n+1 continues from the last draw of beat n.
- FSM states: IDLE, GEN, WAIT.
  - IDLE: in_ready=0, locked=0. On seed_load, state<=seed, clear statistics, go to GEN.
  - GEN: one draw per cycle into the expected-word chunk register. After NCHUNK cycles go to WAIT. in_ready=0.
  - WAIT: in_ready=1. On in_valid&&in_ready, compare the full DATA_W beat, increment beat_count, go to GEN.
- Latency: in_ready rises NCHUNK cycles after a seed_load cycle or an accept cycle. Throughput is 1 beat per NCHUNK+1 cycles.
- Mismatch on accept:
  - err_count += 1, saturating at all-ones.
  - If err_flag=0: set err_flag and capture first_err_beat = pre-increment beat_count.
  - Statistics update on the clock after the accept.
- seed_load in any state:
  - Restarts the stream: clears beat_count, err_count, err_flag, first_err_beat.
  - Next state is GEN.
  - If it coincides with an accept, seed_load wins; the beat is not compared or counted.
- beat_count wraps modulo 2^32. err_count never wraps.
- in_data is ignored when in_ready=0; a held in_valid does not advance the checker.
- Reset (any time, including mid-GEN): state IDLE, all outputs 0, LCG state 0, expected word 0.
- locked=1 from the cycle after seed_load until reset.

Decomposition:
- Package lcg_check_pkg: LCG_MUL_DEF, LCG_INC_DEF, state enum (IDLE, GEN, WAIT), function nchunk(DATA_W).
- Sub-module lcg32_core: 32-bit state register with load (seed) and step enable; outputs the current state.
- The top level holds the FSM, chunk counter, expected-word assembly, compare and statistics.

Test Plan:
- Seed 0, feed the matching stream → chunk0=32'h00003039, chunk1=32'hD3DC167E. After 200 beats: beat_count=200, err_count=0, err_flag=0.
- Seed 0, flip bit 5 of beat 3 only → err_count=1, err_flag=1, first_err_beat=3. Subsequent beats still match (the stream does not desynchronise).
- Corrupt every beat from beat 0 with ERR_W=4 → err_count saturates at 15 after 15 beats and holds; first_err_beat=0.
- seed_load asserted on the same cycle as an accept after 10 beats (seed 362960400) → beat_count=0, no error counted, in_ready low for 5 cycles, then the new stream from that seed matches.
- rst_n pulsed low mid-GEN → all outputs 0, FSM in IDLE, in_ready=0 until the next seed_load.
- Drive in_valid=1 continuously → exactly one accept per 6 cycles (DATA_W=139). in_data is ignored while in_ready=0.
